// File: rtl/nibble_sort_pkg.sv
// Shared types and constants for the four-nibble sorter.
// The schedule lookup maps each step to the left index of the pair it compares.
package nibble_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         NUM_STEPS = 6;
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  // Three passes of a four-element bubble sort, shrinking by one pair each pass.
  function automatic logic [1:0] pair_idx(input logic [2:0] step);
    case (step)
      3'd0:    pair_idx = 2'd0;
      3'd1:    pair_idx = 2'd1;
      3'd2:    pair_idx = 2'd2;
      3'd3:    pair_idx = 2'd0;
      3'd4:    pair_idx = 2'd1;
      default: pair_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/nibble_sort4_ctrl_if.sv
// Producer/consumer bus of the nibble sorter.
// The master drives requests and samples results; the slave is the sorter.
interface nibble_sort4_ctrl_if;
  logic        start;
  logic        desc;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic [2:0]  swap_cnt;

  modport master (
    output start, desc, data_in,
    input  busy, done, data_out, swap_cnt
  );

  modport slave (
    input  start, desc, data_in,
    output busy, done, data_out, swap_cnt
  );
endinterface

// File: rtl/mag_cmp4.sv
// Purely combinational 4-bit unsigned magnitude comparator.
// Exactly one of l/e/g is high for any input pair.
module mag_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       l,
  output logic       e,
  output logic       g
);
  assign l = (a < b);
  assign e = (a == b);
  assign g = (a > b);
endmodule

// File: rtl/nibble_sort4_ctrl.sv
// Sorts four nibbles with a fixed six-step bubble schedule on one shared comparator.
// Results are published only when a sort runs to completion.
module nibble_sort4_ctrl
  import nibble_sort_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  nibble_sort4_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [3:0][3:0]   r_q, r_d;
  logic              desc_q, desc_d;
  logic [2:0]        swap_int_q, swap_int_d;
  logic [15:0]       data_out_q, data_out_d;
  logic [2:0]        swap_cnt_q, swap_cnt_d;

  logic [1:0]        idx;
  logic [3:0]        op_a, op_b;
  logic              cmp_l, cmp_e, cmp_g;
  logic              do_swap;
  logic [3:0][3:0]   r_swapped;

  assign idx  = pair_idx(step_q);
  assign op_a = r_q[idx];
  assign op_b = r_q[idx + 2'd1];

  mag_cmp4 u_cmp (
    .a (op_a),
    .b (op_b),
    .l (cmp_l),
    .e (cmp_e),
    .g (cmp_g)
  );

  // Equal operands never swap, which keeps the sort stable.
  assign do_swap = !cmp_e && (desc_q ? cmp_l : cmp_g);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    r_swapped = r_q;
    if (do_swap) begin
      r_swapped[idx]        = op_b;
      r_swapped[idx + 2'd1] = op_a;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    r_d        = r_q;
    desc_d     = desc_q;
    swap_int_d = swap_int_q;
    data_out_d = data_out_q;
    swap_cnt_d = swap_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          r_d        = bus.data_in;
          desc_d     = bus.desc;
          step_d     = 3'd0;
          swap_int_d = 3'd0;
          state_d    = SORT;
        end
      end
      SORT: begin
        r_d        = r_swapped;
        swap_int_d = swap_int_q + {2'b00, do_swap};
        if (step_q == LAST_STEP) begin
          data_out_d = r_swapped;
          swap_cnt_d = swap_int_q + {2'b00, do_swap};
          step_d     = 3'd0;
          state_d    = DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= 3'd0;
      r_q        <= '0;
      desc_q     <= 1'b0;
      swap_int_q <= 3'd0;
      data_out_q <= 16'h0000;
      swap_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      r_q        <= r_d;
      desc_q     <= desc_d;
      swap_int_q <= swap_int_d;
      data_out_q <= data_out_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.data_out = data_out_q;
  assign bus.swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_nibble_sort4_ctrl.sv
// Self-checking bench for nibble_sort4_ctrl: directed cases plus random sorts
// checked against a counting-sort / inversion-count reference model.
module tb_nibble_sort4_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  nibble_sort4_ctrl_if bus();

  nibble_sort4_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sorted output by counting occurrences of each value.
  function automatic logic [15:0] model_sort(input logic [15:0] d, input logic ds);
    int cnt[16];
    int pos;
    logic [15:0] res;
    int v;
    for (int k = 0; k < 16; k++) cnt[k] = 0;
    for (int k = 0; k < 4; k++) cnt[d[4*k +: 4]]++;
    res = '0;
    pos = 0;
    for (int k = 0; k < 16; k++) begin
      v = ds ? 15 - k : k;
      for (int c = 0; c < cnt[v]; c++) begin
        res[4*pos +: 4] = 4'(v);
        pos++;
      end
    end
    return res;
  endfunction

  // Reference: a stable adjacent-swap sort performs one swap per strict inversion.
  function automatic int model_swaps(input logic [15:0] d, input logic ds);
    int inv = 0;
    for (int j = 0; j < 4; j++)
      for (int k = j + 1; k < 4; k++)
        if (ds ? (d[4*j +: 4] < d[4*k +: 4]) : (d[4*j +: 4] > d[4*k +: 4])) inv++;
    return inv;
  endfunction

  // Runs one sort, checking latency, busy width, single done pulse and result.
  task automatic run_sort(input string tag, input logic [15:0] d, input logic ds,
                          input logic [15:0] exp_out, input int exp_swaps,
                          input bit busy_start);
    int busy_cnt;
    int done_at;
    int done_cnt;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.desc    = ds;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.data_in = 16'($urandom);
    bus.desc    = 1'($urandom);
    busy_cnt = int'(bus.busy);
    done_cnt = int'(bus.done);
    done_at  = -1;
    for (int n = 1; n <= 7; n++) begin
      if (busy_start && n == 3) begin
        bus.start   = 1'b1;
        bus.data_in = 16'h0000;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      busy_cnt += int'(bus.busy);
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    check({tag, "_latency"},  32'(done_at),     32'd6);
    check({tag, "_done_cnt"}, 32'(done_cnt),    32'd1);
    check({tag, "_busy_len"}, 32'(busy_cnt),    32'd7);
    check({tag, "_data"},     32'(bus.data_out), 32'(exp_out));
    check({tag, "_swaps"},    32'(bus.swap_cnt), 32'(exp_swaps));
  endtask

  initial begin
    logic [15:0] rd;
    logic        rdesc;
    logic [31:0] obs_mask;
    logic [31:0] exp_mask;
    int          done_seen;

    bus.start   = 1'b0;
    bus.desc    = 1'b0;
    bus.data_in = 16'h0000;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  32'(bus.busy),     32'd0);
    check("rst_done",  32'(bus.done),     32'd0);
    check("rst_data",  32'(bus.data_out), 32'h0);
    check("rst_swaps", 32'(bus.swap_cnt), 32'd0);

    run_sort("asc_3a1f",    16'h3A1F, 1'b0, 16'hFA31, 4, 1'b0);
    run_sort("desc_3a1f",   16'h3A1F, 1'b1, 16'h13AF, 2, 1'b0);
    run_sort("asc_rev",     16'h0123, 1'b0, 16'h3210, 6, 1'b0);
    run_sort("asc_sorted",  16'hFA31, 1'b0, 16'hFA31, 0, 1'b0);
    run_sort("all_equal",   16'h7777, 1'b0, 16'h7777, 0, 1'b0);
    run_sort("eq_desc",     16'h7777, 1'b1, 16'h7777, 0, 1'b0);
    run_sort("busy_start",  16'h3A1F, 1'b0, 16'hFA31, 4, 1'b1);

    // Start held high: accepted every 8 cycles, so done at offsets 6, 14, 22.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'h5C28;
    bus.desc    = 1'b1;
    @(posedge clk);
    #1;
    obs_mask = '0;
    exp_mask = '0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      #1;
      obs_mask[n] = bus.done;
      exp_mask[n] = ((n % 8) == 6);
    end
    bus.start = 1'b0;
    check("held_done_pattern", obs_mask, exp_mask);
    check("held_data", 32'(bus.data_out), 32'h258C);
    repeat (10) @(posedge clk);

    // Reset during step 3 of a reverse-order sort.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'h0123;
    bus.desc    = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy",  32'(bus.busy),     32'd0);
    check("abort_done",  32'(bus.done),     32'd0);
    check("abort_data",  32'(bus.data_out), 32'h0);
    check("abort_swaps", 32'(bus.swap_cnt), 32'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_sort("post_abort", 16'h0123, 1'b0, 16'h3210, 6, 1'b0);

    for (int t = 0; t < 30; t++) begin
      rd    = 16'($urandom);
      rdesc = 1'($urandom);
      if (t % 5 == 0) rd[7:4] = rd[3:0];
      run_sort("rand", rd, rdesc, model_sort(rd, rdesc), model_swaps(rd, rdesc), (t % 4) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
